// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   SPI mode-0 transaction master for the on-board 4 x 8-bit register slave.
//   One command sends an address byte {rw, 5'b0, addr} followed by len+1 data
//   bytes. Write data is pulled from the host with wr_ready. Read data is
//   returned through rd_data/rd_valid.
//
//   Optional feature (compile-time macro SPI_MASTER_LOOPBACK_EN):
//     adds input `loopback`. When it is sampled high with start, the receive
//     shifter listens to MOSI instead of MISO and SS is kept high for that
//     transaction. SCLK and MOSI still toggle.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             1-clk command strobe (accepted only while busy == 0)
//   rw, addr, len     command fields sampled with start (len = bytes - 1)
//   wr_data           write byte; the first byte is sampled with start
//   wr_ready          1-clk pulse: wr_data captured for data bytes 2..N
//   rd_data, rd_valid last received read byte and its 1-clk update strobe
//   busy, done        transaction in progress / 1-clk end-of-transaction pulse
//   SCLK, MOSI, SS    SPI outputs (SCLK idles low, SS active low)
//   MISO              SPI input, sampled directly on each SCLK rising clk
//   loopback          (SPI_MASTER_LOOPBACK_EN only) internal loopback select
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV    = 8,  // clk cycles per SCLK half-period, >= 4
    parameter int unsigned GAP_CYCLES = 8,  // SCLK-low clks between bytes, >= 6
    parameter int unsigned SS_SETUP   = 4,  // SS low to start of first bit
    parameter int unsigned SS_HOLD    = 4   // last SCLK fall to SS high
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [1:0] len,
    input  logic [7:0] wr_data,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic       loopback,
`endif
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        HOLD
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);

    state_t      state;
    logic [15:0] cnt;        // clk counter shared by every timed state
    logic [2:0]  bit_cnt;    // bit index within the current byte
    logic [2:0]  byte_cnt;   // 0 = address byte, 1..len+1 = data bytes
    logic        rw_q;
    logic [1:0]  len_q;
    logic [7:0]  wr_first;   // first write byte, captured with start
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [7:0]  next_byte;
    logic        last_byte;
    logic        sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q;
    assign sample_bit = lb_q ? MOSI : MISO;
`else
    assign sample_bit = MISO;
`endif

    assign last_byte = (byte_cnt == ({1'b0, len_q} + 3'd1));

    // Byte loaded into the shifter when leaving GAP. Reads send zeros.
    // NOTE: default assignment first so no path leaves next_byte unassigned (no latch).
    always_comb begin
        next_byte = 8'h00;
        if (rw_q) begin
            next_byte = (byte_cnt == 3'd0) ? wr_first : wr_data;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rw_q     <= 1'b0;
            len_q    <= '0;
            wr_first <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            wr_ready <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            SS       <= 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q     <= 1'b0;
`endif
        end else begin
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    // busy is still high in the done clk, so a start arriving
                    // together with done is ignored here.
                    busy <= 1'b0;
                    if (start && !busy) begin
                        rw_q     <= rw;
                        len_q    <= len;
                        wr_first <= wr_data;
                        tx_sr    <= {rw, 5'b0, addr};
                        MOSI     <= rw;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        state    <= SETUP;
`ifdef SPI_MASTER_LOOPBACK_EN
                        lb_q     <= loopback;
                        SS       <= loopback;
`else
                        SS       <= 1'b0;
`endif
                    end
                end

                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        if (!SCLK) begin
                            // Rising edge: sample the slave (or MOSI in loopback).
                            SCLK  <= 1'b1;
                            rx_sr <= {rx_sr[6:0], sample_bit};
                            if (bit_cnt == 3'd7 && byte_cnt != 3'd0 && !rw_q) begin
                                rd_data  <= {rx_sr[6:0], sample_bit};
                                rd_valid <= 1'b1;
                            end
                        end else begin
                            // Falling edge: start of the next low half.
                            SCLK <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                MOSI    <= 1'b0;
                                state   <= last_byte ? HOLD : GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                                MOSI    <= tx_sr[6];
                            end
                        end
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        byte_cnt <= byte_cnt + 3'd1;
                        tx_sr    <= next_byte;
                        MOSI     <= next_byte[7];
                        // Only data bytes 2..N come from the live wr_data bus.
                        wr_ready <= rw_q && (byte_cnt != 3'd0);
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        SS    <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
